ahbl_rom_reader: RTL and testbench

AHB-Lite slave that reads the SoC's synchronous boot/program ROM on behalf of the bus fabric. It drives the ROM's `EN`/`A` inputs during the AHB address phase and returns the ROM's `Do` output in the data phase. An optional registered-output mode adds one wait state for timing closure. Writes and misaligned word accesses get a two-cycle AHB ERROR response.

---
 rtl/rom_pkg.sv | 25 ++
 rtl/ahbl_rom_reader.sv | 115 +++++++++++
 tb/tb_ahbl_rom_reader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// Shared types and constants for the AHB-Lite ROM reader.
package rom_pkg;

    // Data-phase states of the reader.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_ERR1    = 2'b10,
        ST_ERR2    = 2'b11
    } state_e;

    // AHB transfer types.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Largest access size the ROM port supports.
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Slave response encodings.
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahbl_rom_reader.sv
// AHB-Lite slave front end for the synchronous boot/program ROM.
// The ROM is addressed straight from the address phase; read data comes
// back either directly from the ROM (REG_OUT=0) or through a capture
// register that costs one wait state (REG_OUT=1).
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready, OKAY; accepts a new address phase
// ST_RD_WAIT | registered-read wait state, ROM data captured into rd_q
// ST_ERR1    | first ERROR cycle, HREADYOUT low
// ST_ERR2    | second ERROR cycle, HREADYOUT high; accepts a new address phase
module ahbl_rom_reader
    import rom_pkg::*;
#(
    parameter int MEM_WORDS = 8192,
    parameter int ADR_WIDTH = 13,
    parameter int REG_OUT   = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic                 ROM_EN,
    output logic [ADR_WIDTH-1:0] ROM_A,
    input  logic [31:0]          ROM_Do
);

    // The word address must be able to reach every ROM location.
    localparam logic ADR_FITS = ((64'd1 << ADR_WIDTH) >= 64'(MEM_WORDS));

    state_e      state_q, state_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;
    logic [31:0] rd_q;

    logic xfer_valid;
    logic xfer_bad;
    logic xfer_good;

    // Upper address bits, HTRANS[0] and the depth check carry no logic.
    logic unused_inputs;
    assign unused_inputs = ^{HADDR[31:ADR_WIDTH+2], HTRANS[0], ADR_FITS};

    // Classify the address phase currently on the bus.
    always_comb begin
        xfer_valid = HSEL & HREADY & HTRANS[1];
        xfer_bad   = xfer_valid &
                     (HWRITE |
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) |
                      (HSIZE > HSIZE_WORD));
        xfer_good  = xfer_valid & ~xfer_bad;
    end

    // ROM is driven straight from the address phase; bad transfers never reach it.
    assign ROM_EN = xfer_good;
    assign ROM_A  = HADDR[ADR_WIDTH+1:2];

    // Next data-phase state and the response it presents.
    always_comb begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (xfer_bad) begin
                    state_d     = ST_ERR1;
                    hreadyout_d = 1'b0;
                    hresp_d     = HRESP_ERROR;
                end else if (xfer_good && (REG_OUT != 0)) begin
                    state_d     = ST_RD_WAIT;
                    hreadyout_d = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_IDLE;
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = HRESP_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, registered response and captured read data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            if (state_q == ST_RD_WAIT) begin
                rd_q <= ROM_Do;
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (REG_OUT != 0) ? rd_q : ROM_Do;

endmodule

// File: tb/tb_ahbl_rom_reader.sv
// Scoreboard bench for ahbl_rom_reader: one instance per output mode on a
// shared master, each with its own behavioural ROM.
module tb_ahbl_rom_reader;
    import rom_pkg::*;

    localparam int AW = 13;
    localparam int MW = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        force_stall;
    int          mode;

    logic          ro0, ro1, rs0, rs1, en0, en1;
    logic [31:0]   rd0, rd1, do0, do1;
    logic [AW-1:0] a0, a1;

    logic          hready_bus;
    logic          sel_ro, sel_rs, sel_en;
    logic [31:0]   sel_rd;
    logic [AW-1:0] sel_a;

    logic [31:0] mem [MW];

    assign hready_bus = force_stall ? 1'b0 : ((mode == 1) ? ro1 : ro0);
    assign sel_ro = (mode == 1) ? ro1 : ro0;
    assign sel_rs = (mode == 1) ? rs1 : rs0;
    assign sel_en = (mode == 1) ? en1 : en0;
    assign sel_rd = (mode == 1) ? rd1 : rd0;
    assign sel_a  = (mode == 1) ? a1  : a0;

    ahbl_rom_reader #(.MEM_WORDS(MW), .ADR_WIDTH(AW), .REG_OUT(0)) u_dut0 (
        .CLK(clk), .RST(rst), .HSEL(hsel && (mode == 0)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready_bus),
        .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0),
        .ROM_EN(en0), .ROM_A(a0), .ROM_Do(do0)
    );

    ahbl_rom_reader #(.MEM_WORDS(MW), .ADR_WIDTH(AW), .REG_OUT(1)) u_dut1 (
        .CLK(clk), .RST(rst), .HSEL(hsel && (mode == 1)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready_bus),
        .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1),
        .ROM_EN(en1), .ROM_A(a1), .ROM_Do(do1)
    );

    // Synchronous ROMs that hold their output while not enabled.
    always @(posedge clk or posedge rst) begin
        if (rst) do0 <= '0;
        else if (en0) do0 <= mem[a0];
    end
    always @(posedge clk or posedge rst) begin
        if (rst) do1 <= '0;
        else if (en1) do1 <= mem[a1];
    end

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s mode=%0d actual=%h expected=%h t=%0t", name, mode, act, exp, $time);
        end
    endfunction

    function automatic bit is_bad(logic w, logic [2:0] s, logic [31:0] a);
        return w || (s == 3'b010 && a[1:0] != 2'b00) || (s > 3'b010);
    endfunction

    // Monitor: tracks our data phases and compares completions to the queue.
    initial begin
        bit pending;
        bit acc;
        bit bad;
        int waits;
        exp_t e;
        pending = 0;
        waits   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0;
                waits   = 0;
                q.delete();
            end else begin
                acc = hsel && htrans[1] && hready_bus;
                bad = is_bad(hwrite, hsize, haddr);
                chk("rom_en", {31'b0, sel_en}, {31'b0, acc && !bad});
                if (acc && !bad) chk("rom_a", {19'b0, sel_a}, {19'b0, haddr[AW+1:2]});
                if (pending) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty mode=%0d actual=data_phase expected=none", mode);
                        pending = 0;
                    end else if (!hready_bus) begin
                        waits++;
                        chk("hresp_wait", {31'b0, sel_rs}, {31'b0, q[0].err});
                        if (waits > 4) begin
                            e = q.pop_front();
                            chk("wait_bound", 32'(waits), 32'(e.waits));
                            pending = 0;
                            waits   = 0;
                        end
                    end else begin
                        e = q.pop_front();
                        chk("waits", 32'(waits), 32'(e.waits));
                        chk("hresp", {31'b0, sel_rs}, {31'b0, e.err});
                        if (!e.err) chk("hrdata", sel_rd, e.data);
                        pending = 0;
                        waits   = 0;
                    end
                end else begin
                    chk("idle_ready", {30'b0, sel_ro, sel_rs}, 32'b10);
                end
                if (acc) begin
                    pending = 1;
                    waits   = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one address phase, hold it until accepted, record the expected response.
    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [1:0] t);
        exp_t e;
        bit ok;
        hsel   = 1'b1;
        haddr  = a;
        hwrite = w;
        hsize  = s;
        htrans = t;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hready_bus) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout mode=%0d actual=stalled expected=accepted", mode);
        end else if (t[1]) begin
            e.err   = is_bad(w, s, a);
            e.data  = mem[a[AW+1:2]];
            e.waits = e.err ? 1 : ((mode == 1) ? 1 : 0);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic random_traffic(input int n);
        logic [31:0] a;
        int k;
        for (int i = 0; i < n; i++) begin
            a = $urandom();
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3, 4: issue({a[31:2], 2'b00}, 1'b0, 3'b010, (k[0] ? HTRANS_SEQ : HTRANS_NONSEQ));
                5:             issue(a, 1'b0, 3'($urandom_range(0, 1)), HTRANS_NONSEQ);
                6:             issue({a[31:2], 2'($urandom_range(1, 3))}, 1'b0, 3'b010, HTRANS_NONSEQ);
                7:             issue(a, 1'b1, 3'($urandom_range(0, 2)), HTRANS_NONSEQ);
                8:             issue(a, 1'b0, 3'($urandom_range(3, 7)), HTRANS_NONSEQ);
                default:       issue(a, $urandom_range(0, 1) == 1, 3'b010, (k[0] ? HTRANS_BUSY : HTRANS_IDLE));
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
    endtask

    task automatic run_mode(input int m);
        mode = m;
        idle(2);
        issue(32'h0, 1'b0, 3'b010, HTRANS_NONSEQ);
        issue(32'h4, 1'b0, 3'b010, HTRANS_SEQ);
        issue(32'h8, 1'b0, 3'b010, HTRANS_SEQ);
        issue(32'hC, 1'b0, 3'b010, HTRANS_SEQ);
        idle(3);
        issue(32'h10, 1'b1, 3'b010, HTRANS_NONSEQ);
        idle(3);
        issue(32'h6, 1'b0, 3'b010, HTRANS_NONSEQ);
        idle(3);
        issue(32'h6, 1'b0, 3'b000, HTRANS_NONSEQ);
        idle(2);
        issue(32'h10, 1'b1, 3'b010, HTRANS_NONSEQ);
        issue(32'h0, 1'b0, 3'b010, HTRANS_NONSEQ);
        idle(3);
        // A read seen while another slave holds HREADY low must be ignored.
        force_stall = 1'b1;
        hsel   = 1'b1;
        haddr  = 32'h8;
        hwrite = 1'b0;
        hsize  = 3'b010;
        htrans = HTRANS_NONSEQ;
        @(posedge clk);
        #1;
        force_stall = 1'b0;
        idle(1);
        chk("stall_ignored", {31'b0, sel_ro}, 32'd1);
        random_traffic(150);
        drain();
        // Reset during ERR1.
        issue(32'h20, 1'b1, 3'b010, HTRANS_NONSEQ);
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        #1 rst = 1'b1;
        #1;
        chk("rst_err_ready", {31'b0, sel_ro}, 32'd1);
        chk("rst_err_resp", {31'b0, sel_rs}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        if (m == 1) begin
            // Reset during RD_WAIT also clears the capture register.
            issue(32'h4, 1'b0, 3'b010, HTRANS_NONSEQ);
            hsel   = 1'b0;
            htrans = HTRANS_IDLE;
            #1 rst = 1'b1;
            #1;
            chk("rst_rd_ready", {31'b0, sel_ro}, 32'd1);
            chk("rst_rd_resp", {31'b0, sel_rs}, 32'd0);
            chk("rst_rd_data", sel_rd, 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            idle(1);
        end
        issue(32'hC, 1'b0, 3'b010, HTRANS_NONSEQ);
        idle(3);
        drain();
    endtask

    initial begin
        mode        = 0;
        force_stall = 1'b0;
        hsel        = 1'b0;
        haddr       = '0;
        htrans      = HTRANS_IDLE;
        hwrite      = 1'b0;
        hsize       = 3'b010;
        for (int i = 0; i < MW; i++) mem[i] = $urandom();
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        mem[3] = 32'h44444444;
        rst = 1'b1;
        #1;
        chk("reset_ready0", {31'b0, ro0}, 32'd1);
        chk("reset_resp0", {31'b0, rs0}, 32'd0);
        chk("reset_ready1", {31'b0, ro1}, 32'd1);
        chk("reset_resp1", {31'b0, rs1}, 32'd0);
        chk("reset_rdata1", rd1, 32'd0);
        chk("reset_rom_en", {30'b0, en0, en1}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_mode(0);
        run_mode(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
